// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types for the MEM/WB stage
package mem_wb_pkg;

    localparam int WIDTH = 32;

    // Writeback source select driven by decode
    typedef enum logic [2:0] {
        RF_ALU_OUT  = 3'd0,
        RF_BR_EN    = 3'd1,
        RF_U_IMM    = 3'd2,
        RF_LW       = 3'd3,
        RF_PC_PLUS4 = 3'd4
    } regfilemux_sel_t;

    // Load width/sign encodings (RV32I funct3)
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    // Data-memory handshake state
    typedef enum logic {
        MW_IDLE = 1'b0,
        MW_BUSY = 1'b1
    } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - byte/half/word selection and extension of load data
module mem_wb_stage_load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword pick uses only off[1]; misaligned halves are not split across words
    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extend the selected lane; unknown funct3 values fall back to the whole word
    always_comb begin
        o_value = i_rdata;
        case (i_funct3)
            LD_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_value = {{16{w_half[15]}}, w_half};
            LD_LBU:  o_value = {24'b0, w_byte};
            LD_LHU:  o_value = {16'b0, w_half};
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - data-memory handshake and MEM/WB pipeline register
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [width-1:0] mem_alu_out_i,
    input  logic [width-1:0] mem_addr_i,
    input  logic [width-1:0] mem_wdata_i,
    input  logic [3:0]       mem_byte_en_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       mem_funct3_i,
    input  logic [2:0]       mem_rfmux_sel_i,
    input  logic             mem_load_rf_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_br_en_i,
    input  logic [width-1:0] mem_u_imm_i,
    input  logic [width-1:0] mem_pc_plus4_i,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [width-1:0] dmem_addr_o,
    output logic [width-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_byte_en_o,
    input  logic [width-1:0] dmem_rdata_i,
    input  logic             dmem_resp_i,
    output logic             stall_o,
    output logic             wb_valid_o,
    output logic             wb_load_rf_o,
    output logic [4:0]       wb_rd_o,
    output logic [width-1:0] wb_data_o
);

    mem_wb_state_t    r_state;
    mem_wb_state_t    w_state_next;
    logic             r_req_read;
    logic             r_req_write;
    logic [width-1:0] r_req_addr;
    logic [width-1:0] r_req_wdata;
    logic [3:0]       r_req_be;
    logic             r_wb_valid;
    logic             r_wb_load_rf;
    logic [4:0]       r_wb_rd;
    logic [width-1:0] r_wb_data;
    logic             w_mem_op;
    logic             w_stall;
    logic             w_wb_load;
    logic [width-1:0] w_load_val;
    logic [width-1:0] w_wb_data;

    assign w_mem_op = mem_valid_i & (mem_read_i | mem_write_i);

    // Offset comes from the captured request so it matches the access in flight
    mem_wb_stage_load_align u_load_align (
        .i_rdata  (dmem_rdata_i),
        .i_off    (r_req_addr[1:0]),
        .i_funct3 (mem_funct3_i),
        .o_value  (w_load_val)
    );

    // Next state, stall and WB-register load enable
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_wb_load    = 1'b0;
        case (r_state)
            MW_IDLE: begin
                w_stall   = w_mem_op;
                w_wb_load = ~w_mem_op;
                if (w_mem_op) begin
                    w_state_next = MW_BUSY;
                end
            end
            MW_BUSY: begin
                w_stall   = ~dmem_resp_i;
                w_wb_load = dmem_resp_i;
                if (dmem_resp_i) begin
                    w_state_next = MW_IDLE;
                end
            end
            default: w_state_next = MW_IDLE;
        endcase
    end

    // Writeback value select; unlisted encodings behave as alu_out
    always_comb begin
        w_wb_data = mem_alu_out_i;
        case (mem_rfmux_sel_i)
            RF_ALU_OUT:  w_wb_data = mem_alu_out_i;
            RF_BR_EN:    w_wb_data = {{(width-1){1'b0}}, mem_br_en_i};
            RF_U_IMM:    w_wb_data = mem_u_imm_i;
            RF_LW:       w_wb_data = w_load_val;
            RF_PC_PLUS4: w_wb_data = mem_pc_plus4_i;
            default:     w_wb_data = mem_alu_out_i;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MW_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request registers: captured on entry to BUSY, strobes cleared after the response
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_read  <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= 4'b0;
        end else if (r_state == MW_IDLE && w_mem_op) begin
            r_req_read  <= mem_read_i;
            r_req_write <= mem_write_i & ~mem_read_i;
            r_req_addr  <= mem_addr_i;
            r_req_wdata <= mem_wdata_i;
            r_req_be    <= mem_byte_en_i;
        end else if (r_state == MW_BUSY && dmem_resp_i) begin
            r_req_read  <= 1'b0;
            r_req_write <= 1'b0;
        end
    end

    // MEM/WB pipeline register; holds while a memory access is outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_valid   <= 1'b0;
            r_wb_load_rf <= 1'b0;
            r_wb_rd      <= 5'b0;
            r_wb_data    <= '0;
        end else if (w_wb_load) begin
            r_wb_valid   <= mem_valid_i;
            r_wb_load_rf <= mem_valid_i & mem_load_rf_i;
            r_wb_rd      <= mem_rd_i;
            r_wb_data    <= w_wb_data;
        end
    end

    assign dmem_read_o    = r_req_read;
    assign dmem_write_o   = r_req_write;
    assign dmem_addr_o    = {r_req_addr[width-1:2], 2'b00};
    assign dmem_wdata_o   = r_req_wdata;
    assign dmem_byte_en_o = r_req_be;
    assign stall_o        = w_stall;
    assign wb_valid_o     = r_wb_valid;
    assign wb_load_rf_o   = r_wb_load_rf;
    assign wb_rd_o        = r_wb_rd;
    assign wb_data_o      = r_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_alu_out_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_byte_en_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  mem_funct3_i;
    logic [2:0]  mem_rfmux_sel_i;
    logic        mem_load_rf_i;
    logic [4:0]  mem_rd_i;
    logic        mem_br_en_i;
    logic [31:0] mem_u_imm_i;
    logic [31:0] mem_pc_plus4_i;
    logic        dmem_read_o;
    logic        dmem_write_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_byte_en_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_resp_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic        wb_load_rf_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_alu_out_i(mem_alu_out_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_byte_en_i(mem_byte_en_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mem_funct3_i(mem_funct3_i),
        .mem_rfmux_sel_i(mem_rfmux_sel_i), .mem_load_rf_i(mem_load_rf_i),
        .mem_rd_i(mem_rd_i), .mem_br_en_i(mem_br_en_i),
        .mem_u_imm_i(mem_u_imm_i), .mem_pc_plus4_i(mem_pc_plus4_i),
        .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_byte_en_o(dmem_byte_en_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_resp_i(dmem_resp_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_load_rf_o(wb_load_rf_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );

    // Reference: extract the addressed lane arithmetically and extend it
    function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off, input int f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (off * 8)) & 32'hFF;
        h = (rdata >> ((off / 2) * 16)) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4: return b;
            5: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_wb(input int sel, input logic [31:0] alu, input logic br,
                                           input logic [31:0] uimm, input logic [31:0] pc4,
                                           input logic [31:0] rdata, input int off, input int f3);
        case (sel)
            1: return br ? 32'd1 : 32'd0;
            2: return uimm;
            3: return load_model(rdata, off, f3);
            4: return pc4;
            default: return alu;
        endcase
    endfunction

    task automatic drive_bubble();
        mem_valid_i = 0; mem_alu_out_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        mem_byte_en_i = 0; mem_read_i = 0; mem_write_i = 0; mem_funct3_i = 0;
        mem_rfmux_sel_i = 0; mem_load_rf_i = 0; mem_rd_i = 0; mem_br_en_i = 0;
        mem_u_imm_i = 0; mem_pc_plus4_i = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Non-memory instruction or bubble; starts and ends 1 unit after a rising edge
    task automatic alu_op(input string name, input logic valid, input logic [2:0] sel,
                          input logic [31:0] alu, input logic ld, input logic [4:0] rd);
        logic [31:0] exp;
        mem_valid_i = valid; mem_read_i = 0; mem_write_i = 0;
        mem_rfmux_sel_i = sel; mem_alu_out_i = alu; mem_load_rf_i = ld; mem_rd_i = rd;
        mem_br_en_i = 1'($urandom); mem_u_imm_i = $urandom; mem_pc_plus4_i = $urandom;
        mem_addr_i = $urandom; mem_funct3_i = 3'($urandom);
        exp = exp_wb(int'(sel), alu, mem_br_en_i, mem_u_imm_i, mem_pc_plus4_i, 32'h0, 0, 2);
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL %s stall got=%b exp=0", name, stall_o); end
        tick();
        drive_bubble();
        @(negedge clk);
        checks++;
        if (wb_valid_o !== valid || wb_load_rf_o !== (valid & ld)) begin
            errors++;
            $display("FAIL %s wb_valid/load_rf got=%b/%b exp=%b/%b", name, wb_valid_o, wb_load_rf_o, valid, valid & ld);
        end
        if (valid) begin
            checks++;
            if (wb_rd_o !== rd || wb_data_o !== exp) begin
                errors++;
                $display("FAIL %s wb rd/data got=%0d/%h exp=%0d/%h", name, wb_rd_o, wb_data_o, rd, exp);
            end
        end
        tick();
    endtask

    // Load or store with a memory that answers lat cycles after the request appears
    task automatic mem_op(input string name, input logic rd_, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [2:0] f3,
                          input logic [2:0] sel, input logic ld, input logic [4:0] rd,
                          input logic [31:0] rdata, input int lat, output logic [31:0] got);
        logic [31:0] exp;
        logic        exp_rd;
        logic        exp_wr;
        mem_valid_i = 1; mem_read_i = rd_; mem_write_i = wr; mem_addr_i = addr;
        mem_wdata_i = wdata; mem_byte_en_i = be; mem_funct3_i = f3; mem_rfmux_sel_i = sel;
        mem_load_rf_i = ld; mem_rd_i = rd; mem_alu_out_i = $urandom; mem_br_en_i = 1'($urandom);
        mem_u_imm_i = $urandom; mem_pc_plus4_i = $urandom;
        exp_rd = rd_;
        exp_wr = wr & ~rd_;
        exp = exp_wb(int'(sel), mem_alu_out_i, mem_br_en_i, mem_u_imm_i, mem_pc_plus4_i,
                     rdata, int'(addr % 4), int'(f3));
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL %s issue stall got=%b exp=1", name, stall_o); end
        tick();
        for (int c = 0; c <= lat; c++) begin
            if (c == lat) begin
                dmem_resp_i = 1; dmem_rdata_i = rdata;
            end else begin
                dmem_rdata_i = $urandom;
            end
            @(negedge clk);
            checks++;
            if (stall_o !== (c != lat) || dmem_read_o !== exp_rd || dmem_write_o !== exp_wr ||
                dmem_addr_o !== (addr & 32'hFFFF_FFFC) || dmem_wdata_o !== wdata || dmem_byte_en_o !== be) begin
                errors++;
                $display("FAIL %s busy cyc%0d stall/rd/wr/addr/wdata/be got=%b/%b/%b/%h/%h/%h exp=%b/%b/%b/%h/%h/%h",
                         name, c, stall_o, dmem_read_o, dmem_write_o, dmem_addr_o, dmem_wdata_o, dmem_byte_en_o,
                         c != lat, exp_rd, exp_wr, addr & 32'hFFFF_FFFC, wdata, be);
            end
            tick();
        end
        dmem_resp_i = 0;
        drive_bubble();
        @(negedge clk);
        got = wb_data_o;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_load_rf_o !== ld || wb_rd_o !== rd || wb_data_o !== exp ||
            dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s wb valid/load_rf/rd/data/rd_req/wr_req got=%b/%b/%0d/%h/%b/%b exp=1/%b/%0d/%h/0/0",
                     name, wb_valid_o, wb_load_rf_o, wb_rd_o, wb_data_o, dmem_read_o, dmem_write_o, ld, rd, exp);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 0; dmem_resp_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        drive_bubble();
        mem_valid_i = 1; mem_read_i = 1;
        repeat (2) @(posedge clk);
        #1;
        drive_bubble();
        @(negedge clk);
        checks++;
        if ({dmem_read_o, dmem_write_o, dmem_addr_o, dmem_wdata_o, dmem_byte_en_o,
             wb_valid_o, wb_load_rf_o, wb_rd_o, wb_data_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs rd=%b wr=%b addr=%h wd=%h be=%h wbv=%b wbl=%b rd=%0d d=%h exp all 0",
                     dmem_read_o, dmem_write_o, dmem_addr_o, dmem_wdata_o, dmem_byte_en_o,
                     wb_valid_o, wb_load_rf_o, wb_rd_o, wb_data_o);
        end
        tick();
        rst = 1; dmem_resp_i = 0;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || dmem_read_o !== 1'b0) begin
            errors++; $display("FAIL reset_release stall/read got=%b/%b exp=0/0", stall_o, dmem_read_o);
        end
        tick();
    endtask

    task automatic test_alu();
        alu_op("alu_basic", 1, 3'd0, 32'h1234, 1, 5'd5);
        alu_op("br_en", 1, 3'd1, 32'hAAAA_0000, 1, 5'd7);
        alu_op("sel_other", 1, 3'd6, 32'h0BAD_F00D, 1, 5'd9);
    endtask

    task automatic test_loads();
        logic [31:0] got;
        mem_op("lb", 1, 0, 32'h103, 0, 4'h8, 3'b000, 3'd3, 1, 5'd3, 32'h80FF_0000, 3, got);
        checks++;
        if (got !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value got=%h exp=ffffff80", got); end
        mem_op("lhu", 1, 0, 32'h102, 0, 4'hC, 3'b101, 3'd3, 1, 5'd4, 32'hBEEF_1234, 1, got);
        checks++;
        if (got !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_value got=%h exp=0000beef", got); end
        mem_op("lh", 1, 0, 32'h102, 0, 4'hC, 3'b001, 3'd3, 1, 5'd4, 32'hBEEF_1234, 2, got);
        checks++;
        if (got !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_value got=%h exp=ffffbeef", got); end
        mem_op("read_wins", 1, 1, 32'h40, 32'h1, 4'hF, 3'b010, 3'd3, 1, 5'd8, 32'h1357_9BDF, 1, got);
    endtask

    task automatic test_store();
        logic [31:0] got;
        mem_op("sw", 0, 1, 32'h200, 32'hDEAD_BEEF, 4'hF, 3'b010, 3'd0, 0, 5'd0, 32'h0, 2, got);
    endtask

    task automatic test_reset_busy();
        mem_valid_i = 1; mem_read_i = 1; mem_addr_i = 32'h300; mem_funct3_i = 3'b010;
        mem_rfmux_sel_i = 3'd3; mem_load_rf_i = 1; mem_rd_i = 5'd12;
        tick();
        @(negedge clk);
        checks++;
        if (dmem_read_o !== 1'b1) begin errors++; $display("FAIL rbusy_req got=%b exp=1", dmem_read_o); end
        #1 rst = 0;
        drive_bubble();
        tick();
        rst = 1; dmem_resp_i = 1; dmem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (dmem_read_o !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_load_rf_o !== 1'b0 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rbusy_after read/stall/wbv/wbl/data got=%b/%b/%b/%b/%h exp=0/0/0/0/0",
                     dmem_read_o, stall_o, wb_valid_o, wb_load_rf_o, wb_data_o);
        end
        tick();
        dmem_resp_i = 0;
        @(negedge clk);
        checks++;
        if (wb_valid_o !== 1'b0 || wb_load_rf_o !== 1'b0 || wb_data_o !== 32'h0 || dmem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL rbusy_late_resp wbv/wbl/data/read got=%b/%b/%h/%b exp=0/0/0/0",
                     wb_valid_o, wb_load_rf_o, wb_data_o, dmem_read_o);
        end
        tick();
    endtask

    task automatic test_bubble();
        alu_op("bubble", 0, 3'd0, 32'h7777, 1, 5'd11);
        dmem_resp_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL spurious_stall got=%b exp=0", stall_o); end
        tick();
        dmem_resp_i = 0;
        @(negedge clk);
        checks++;
        if (wb_valid_o !== 1'b0 || wb_load_rf_o !== 1'b0 || dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_resp wbv/wbl/rd/wr got=%b/%b/%b/%b exp=0/0/0/0",
                     wb_valid_o, wb_load_rf_o, dmem_read_o, dmem_write_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [2:0]  sel;
        logic [2:0]  f3;
        int          f3s[5] = '{0, 1, 2, 4, 5};
        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(7));
            if (sel == 3'd3) sel = 3'd0;
            case ($urandom_range(3))
                0: alu_op("rnd_alu", 1, sel, $urandom, 1'($urandom), 5'($urandom));
                1: begin
                    f3 = 3'(f3s[$urandom_range(4)]);
                    mem_op("rnd_load", 1, 0, $urandom, $urandom, 4'($urandom), f3, 3'd3, 1,
                           5'($urandom), $urandom, int'($urandom_range(1, 4)), got);
                end
                2: mem_op("rnd_store", 0, 1, $urandom, $urandom, 4'($urandom), 3'($urandom), sel, 0,
                          5'($urandom), $urandom, int'($urandom_range(1, 4)), got);
                default: alu_op("rnd_bubble", 0, sel, $urandom, 1'($urandom), 5'($urandom));
            endcase
        end
    endtask

    initial begin
        drive_bubble();
        rst = 0; dmem_resp_i = 0; dmem_rdata_i = 0;
        test_reset();
        test_alu();
        test_loads();
        test_store();
        test_reset_busy();
        test_bubble();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
